des_perm_pipe: RTL and testbench

Parametrised, pipelined DES bit-permutation engine with a valid/ready handshake. Each beat applies the initial permutation (IP), the final permutation (FP = IP⁻¹) or bypass, selected per beat. An optional sideband tag travels with each beat. It sits between the block-input staging logic and the round datapath (IP mode), and between the round datapath and the output staging (FP mode). It replaces the fixed combinational initial-permutation wiring.

---
 rtl/des_perm_pipe.sv | 113 +++++++++++
 tb/tb_des_perm_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_perm_pipe.sv
// rtl/des_perm_pipe.sv - pipelined DES IP/FP bit-permutation engine with valid/ready handshake
module des_perm_pipe #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [15:0]      beat_count
);

    logic             valid_q [STAGES];
    logic [63:0]      data_q  [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];
    logic [STAGES-1:0] ready;
    logic [63:0]      ip_w;
    logic [63:0]      fp_w;
    logic [63:0]      perm_d;
    logic [15:0]      beat_count_q;
    logic [15:0]      beat_count_d;

    // Source bit of IP output bit i; FP scatters through the same mapping.
    function automatic logic [5:0] ip_src(input int i);
        return 6'(57 - 8 * (i % 8) + 2 * ((i / 8) % 4) - (i / 32));
    endfunction

    always_comb begin
        ip_w = '0;
        fp_w = '0;
        for (int i = 0; i < 64; i++) begin
            ip_w[i]         = in_data[ip_src(i)];
            fp_w[ip_src(i)] = in_data[i];
        end
        case (in_mode)
            2'b01:   perm_d = ip_w;
            2'b10:   perm_d = fp_w;
            default: perm_d = in_data;
        endcase
    end

    // ready_k unrolled: out_ready or any empty stage at or after k.
    always_comb begin
        logic acc;
        ready = '0;
        acc   = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc      = acc || !valid_q[k];
            ready[k] = acc;
        end
    end

    assign in_ready  = ready[0] && !flush;
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign beat_count = beat_count_q;

    always_comb begin
        beat_count_d = beat_count_q;
        if (out_valid && out_ready) begin
            beat_count_d = beat_count_q + 16'd1;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            busy = busy | valid_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                tag_q[k]   <= '0;
            end
            beat_count_q <= '0;
        end else begin
            beat_count_q <= beat_count_d;
            if (ready[0]) begin
                valid_q[0] <= in_valid && in_ready;
                data_q[0]  <= perm_d;
                tag_q[0]   <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    data_q[k]  <= data_q[k-1];
                    tag_q[k]   <= tag_q[k-1];
                end
            end
            // Flush drops beats only; data and tag registers keep their contents.
            if (flush) begin
                for (int k = 0; k < STAGES; k++) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_des_perm_pipe.sv
// tb/tb_des_perm_pipe.sv - self-checking bench for des_perm_pipe against a table-driven DES model
module tb_des_perm_pipe;

    localparam int STAGES = 3;
    localparam int TAG_W  = 4;

    typedef logic [63+TAG_W:0] beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_data = '0;
    logic [1:0]       in_mode = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic [15:0]      beat_count;

    int checks = 0;
    int errors = 0;
    int exp_beats = 0;
    int spurious = 0;
    logic last_acc;
    beat_t pend_q[$];
    beat_t got_q[$];
    beat_t exp_q[$];

    // Standard DES IP table (1-based DES bit numbers).
    int ip_tab[64] = '{58, 50, 42, 34, 26, 18, 10, 2,
                       60, 52, 44, 36, 28, 20, 12, 4,
                       62, 54, 46, 38, 30, 22, 14, 6,
                       64, 56, 48, 40, 32, 24, 16, 8,
                       57, 49, 41, 33, 25, 17,  9, 1,
                       59, 51, 43, 35, 27, 19, 11, 3,
                       61, 53, 45, 37, 29, 21, 13, 5,
                       63, 55, 47, 39, 31, 23, 15, 7};

    des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_perm(input logic [63:0] x, input logic [1:0] mode);
        logic [63:0] r;
        r = x;
        for (int j = 0; j < 64; j++) begin
            if (mode == 2'b01) r[j] = x[ip_tab[j]-1];
            if (mode == 2'b10) r[ip_tab[j]-1] = x[j];
        end
        return r;
    endfunction

    // One clock: record handshakes seen before the edge, then step past it.
    task automatic tick();
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            exp_beats++;
            if (pend_q.size() > 0) begin
                got_q.push_back({out_data, out_tag});
                exp_q.push_back(pend_q.pop_front());
            end else begin
                spurious++;
            end
        end
        if (last_acc) pend_q.push_back({ref_perm(in_data, in_mode), in_tag});
        if (flush) pend_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (beat_count !== 16'h0) begin errors++; $display("FAIL reset_beat_count got %h want 0", beat_count); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_ip_single();
        logic [63:0] vin [2];
        logic [63:0] vout [2];
        int k;
        beat_t g;
        vin[0] = 64'h0200_0000_0000_0000; vout[0] = 64'h0000_0000_0000_0001;
        vin[1] = 64'h0000_0000_0000_0040; vout[1] = 64'h8000_0000_0000_0000;
        out_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            in_valid = 1'b1; in_data = vin[v]; in_mode = 2'b01; in_tag = TAG_W'(v + 5);
            tick();
            checks++; if (last_acc !== 1'b1) begin errors++; $display("FAIL ip_accept got %b want 1", last_acc); end
            in_valid = 1'b0;
            k = 0;
            while (!out_valid && k < 20) begin tick(); k++; end
            checks++; if (k != STAGES - 1) begin errors++; $display("FAIL ip_latency got %0d want %0d", k, STAGES - 1); end
            tick();
            checks++;
            if (got_q.size() != 1) begin
                errors++; $display("FAIL ip_output_count got %0d want 1", got_q.size());
            end else begin
                g = got_q.pop_front();
                void'(exp_q.pop_front());
                if (g !== {vout[v], TAG_W'(v + 5)}) begin
                    errors++; $display("FAIL ip_single got %h want %h", g, {vout[v], TAG_W'(v + 5)});
                end
            end
            got_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_round_trip();
        localparam int N = 1000;
        logic [63:0] words [N];
        logic [63:0] mid [N];
        int sent, rcv, guard;
        beat_t g, e;
        for (int i = 0; i < N; i++) words[i] = {$urandom, $urandom};
        for (int pass = 0; pass < 2; pass++) begin
            sent = 0; rcv = 0; guard = 0;
            while (rcv < N && guard < 20000) begin
                in_valid = (sent < N);
                in_data  = (sent < N) ? ((pass == 0) ? words[sent] : mid[sent]) : 64'h0;
                in_mode  = (pass == 0) ? 2'b01 : 2'b10;
                in_tag   = TAG_W'(sent);
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
                if (last_acc) sent++;
                while (got_q.size() > 0) begin
                    g = got_q.pop_front();
                    e = exp_q.pop_front();
                    checks++;
                    if (g !== e) begin errors++; $display("FAIL rt_model pass %0d idx %0d got %h want %h", pass, rcv, g, e); end
                    if (pass == 0) begin
                        mid[rcv] = g[63+TAG_W:TAG_W];
                    end else begin
                        checks++;
                        if (g[63+TAG_W:TAG_W] !== words[rcv]) begin
                            errors++; $display("FAIL rt_inverse idx %0d got %h want %h", rcv, g[63+TAG_W:TAG_W], words[rcv]);
                        end
                    end
                    rcv++;
                end
                guard++;
            end
            in_valid = 1'b0;
            checks++; if (rcv != N) begin errors++; $display("FAIL rt_timeout pass %0d got %0d beats want %0d", pass, rcv, N); end
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL rt_spurious got %0d want 0", spurious); end
        checks++; if (beat_count !== 16'(exp_beats)) begin errors++; $display("FAIL rt_beat_count got %h want %h", beat_count, 16'(exp_beats)); end
    endtask

    task automatic test_bypass();
        localparam int N = 64;
        logic [63:0] orig [N];
        int sent, rcv, guard;
        beat_t g;
        for (int i = 0; i < N; i++) orig[i] = {$urandom, $urandom};
        sent = 0; rcv = 0; guard = 0;
        while (rcv < N && guard < 2000) begin
            in_valid  = (sent < N);
            in_data   = (sent < N) ? orig[sent] : 64'h0;
            in_mode   = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            in_tag    = TAG_W'(sent * 7);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (last_acc) sent++;
            while (got_q.size() > 0) begin
                g = got_q.pop_front();
                void'(exp_q.pop_front());
                checks++;
                if (g !== {orig[rcv], TAG_W'(rcv * 7)}) begin
                    errors++; $display("FAIL bypass idx %0d got %h want %h", rcv, g, {orig[rcv], TAG_W'(rcv * 7)});
                end
                rcv++;
            end
            guard++;
        end
        in_valid = 1'b0;
        checks++; if (rcv != N) begin errors++; $display("FAIL bypass_timeout got %0d want %0d", rcv, N); end
    endtask

    task automatic test_back_pressure();
        int sent, rcv;
        logic [63:0] hold_d;
        logic [TAG_W-1:0] hold_t;
        beat_t g, e;
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (sent < 4);
            in_tag   = TAG_W'(sent + 1);
            in_data  = {$urandom, $urandom};
            in_mode  = 2'($urandom_range(0, 3));
            tick();
            if (last_acc) sent++;
        end
        checks++; if (sent != STAGES) begin errors++; $display("FAIL bp_accepts got %0d want %0d", sent, STAGES); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
        hold_d = out_data; hold_t = out_tag;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_tag !== hold_t) begin
            errors++; $display("FAIL bp_stable got %b/%h/%h want 1/%h/%h", out_valid, out_data, out_tag, hold_d, hold_t);
        end
        checks++; if (hold_t !== TAG_W'(1)) begin errors++; $display("FAIL bp_head_tag got %h want 1", hold_t); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_chain got %b want 1", in_ready); end
        for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
            in_valid = (sent < 4);
            in_tag   = TAG_W'(sent + 1);
            in_data  = {$urandom, $urandom};
            tick();
            if (last_acc) sent++;
        end
        in_valid = 1'b0;
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got_q.size()); end
        rcv = 1;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g[TAG_W-1:0] !== TAG_W'(rcv) || g !== e) begin
                errors++; $display("FAIL bp_order idx %0d got %h want tag %0d beat %h", rcv, g, rcv, e);
            end
            rcv++;
        end
        tick(); tick();
        checks++; if (got_q.size() != 0 || spurious != 0) begin errors++; $display("FAIL bp_duplicate got %0d extra want 0", got_q.size() + spurious); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_flush();
        int sent;
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 10 && sent < 2; c++) begin
            in_valid = 1'b1; in_data = {$urandom, $urandom}; in_mode = 2'b01; in_tag = TAG_W'(c);
            tick();
            if (last_acc) sent++;
        end
        in_data = {$urandom, $urandom};
        flush = 1'b1;
        tick();
        checks++; if (last_acc !== 1'b0) begin errors++; $display("FAIL flush_accept got %b want 0", last_acc); end
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        checks++; if (beat_count !== 16'(exp_beats)) begin errors++; $display("FAIL flush_beat_count got %h want %h", beat_count, 16'(exp_beats)); end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        checks++; if (got_q.size() != 0 || spurious != 0) begin errors++; $display("FAIL flush_leak got %0d want 0", got_q.size() + spurious); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = {$urandom, $urandom}; in_mode = 2'b00; in_tag = TAG_W'(c);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL areset_out_data got %h want 0", out_data); end
        checks++; if (beat_count !== 16'h0) begin errors++; $display("FAIL areset_beat_count got %h want 0", beat_count); end
        in_valid = 1'b0;
        pend_q.delete(); got_q.delete(); exp_q.delete();
        exp_beats = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        int guard;
        in_valid = 1'b1; in_mode = 2'b00; out_ready = 1'b1;
        guard = 0;
        while (exp_beats < 65537 && guard < 70000) begin
            in_data = {$urandom, $urandom};
            tick();
            got_q.delete(); exp_q.delete();
            guard++;
        end
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (exp_beats != 65537) begin errors++; $display("FAIL wrap_timeout got %0d want 65537", exp_beats); end
        checks++; if (beat_count !== 16'h0001) begin errors++; $display("FAIL wrap_beat_count got %h want 0001", beat_count); end
    endtask

    initial begin
        test_reset();
        test_ip_single();
        test_round_trip();
        test_bypass();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
